router_fsm: RTL



---
 rtl/router_pkg.sv | 24 ++
 rtl/router_if.sv | 37 +++
 rtl/router_fsm.sv | 92 +++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router: FSM state encoding and
// destination-address limits used by the register stage, synchronizer and FSM.
package router_pkg;

  localparam int NUM_PORTS = 3;
  localparam int ADDR_W    = 2;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_e;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a != ADDR_INVALID) && (int'(a) < NUM_PORTS);
  endfunction

endpackage

// File: rtl/router_if.sv
// Control bundle between the router FSM and its neighbours (source, register
// stage, synchronizer). The FSM takes the slave side.
interface router_if;
  import router_pkg::*;

  logic                 pkt_valid;
  logic [ADDR_W-1:0]    data_in;
  logic                 fifo_full;
  logic [NUM_PORTS-1:0] fifo_empty;
  logic [NUM_PORTS-1:0] soft_reset;
  logic                 parity_done;
  logic                 low_pkt_valid;

  logic detect_add;
  logic lfd_state;
  logic ld_state;
  logic laf_state;
  logic full_state;
  logic rst_int_reg;
  logic write_enb_reg;
  logic busy;

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
           parity_done, low_pkt_valid,
    input  detect_add, lfd_state, ld_state, laf_state, full_state,
           rst_int_reg, write_enb_reg, busy
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
           parity_done, low_pkt_valid,
    output detect_add, lfd_state, ld_state, laf_state, full_state,
           rst_int_reg, write_enb_reg, busy
  );

endinterface

// File: rtl/router_fsm.sv
// Input-side control FSM of the 1x3 router: decodes the header destination,
// sequences header/payload/stall/parity writes and drives Moore-decoded strobes.
module router_fsm
  import router_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  router_if.slave  bus
);

  localparam int SEL_W = 1 << ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SEL_W-1:0]  empty_ext, soft_ext;
  logic              hdr_ok, soft_hit;

  // Widen per-port flags to the full address space so any index is in range.
  assign empty_ext = SEL_W'(bus.fifo_empty);
  assign soft_ext  = SEL_W'(bus.soft_reset);
  assign hdr_ok    = bus.pkt_valid && addr_ok(bus.data_in);
  assign soft_hit  = soft_ext[addr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      DECODE_ADDRESS: begin
        if (hdr_ok) begin
          addr_d  = bus.data_in;
          state_d = empty_ext[bus.data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!bus.pkt_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (bus.parity_done)        state_d = DECODE_ADDRESS;
        else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
        else                        state_d = LOAD_DATA;
      end
      LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      WAIT_TILL_EMPTY: begin
        if (empty_ext[addr_q]) state_d = LOAD_FIRST_DATA;
      end
      default: state_d = DECODE_ADDRESS;
    endcase
    // A timeout on the selected FIFO abandons the packet from any active state.
    if (state_q != DECODE_ADDRESS && soft_hit) state_d = DECODE_ADDRESS;
  end

  logic da, lfd, ld, laf, ffs, cpe, wen, bsy;

  always_comb begin
    da  = (state_q == DECODE_ADDRESS);
    lfd = (state_q == LOAD_FIRST_DATA);
    ld  = (state_q == LOAD_DATA);
    laf = (state_q == LOAD_AFTER_FULL);
    ffs = (state_q == FIFO_FULL_STATE);
    cpe = (state_q == CHECK_PARITY_ERROR);
    wen = ld || laf || (state_q == LOAD_PARITY);
    bsy = !(da || ld);
  end

  assign bus.detect_add    = da;
  assign bus.lfd_state     = lfd;
  assign bus.ld_state      = ld;
  assign bus.laf_state     = laf;
  assign bus.full_state    = ffs;
  assign bus.rst_int_reg   = cpe;
  assign bus.write_enb_reg = wen;
  assign bus.busy          = bsy;

endmodule
